// File: rtl/fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arbiter
// Brief    : Round-robin multi-channel FIFO writer with an independent
//            read/load sequencer feeding a downstream sink.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int FIFO_WIDTH = 63
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [NUM_CH-1:0]            ch_req,
   input  logic [NUM_CH*FIFO_WIDTH-1:0] ch_data,
   output logic [NUM_CH-1:0]            ch_ack,
   output logic [FIFO_WIDTH-1:0]        fifo_data_in,
   output logic                         fifo_write_n,
   output logic                         fifo_read_n,
   input  logic                         fifo_full,
   input  logic                         fifo_empty,
   input  logic                         tx_ready,
   output logic                         tx_load,
   output logic [7:0]                   stall_cnt
);

   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [0:0] {
      W_IDLE  = 1'b0,
      W_WRITE = 1'b1
   } wstate_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_READ = 2'd1,
      R_LOAD = 2'd2
   } rstate_t;

   wstate_t                 w_state_q, w_state_d;
   rstate_t                 r_state_q, r_state_d;
   logic [IW-1:0]           last_grant_q, last_grant_d;
   logic [NUM_CH-1:0]       ack_q, ack_d;
   logic [FIFO_WIDTH-1:0]   data_q, data_d;
   logic [7:0]              stall_q, stall_d;

   logic [IW-1:0]           sel_idx;
   logic                    sel_found;

   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin
      int            cand;
      logic [IW-1:0] cand_idx;
      sel_idx   = '0;
      sel_found = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = int'(last_grant_q) + k;
         if (cand >= NUM_CH) begin
            cand = cand - NUM_CH;
         end
         cand_idx = IW'(cand);
         if (!sel_found && ch_req[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      w_state_d    = w_state_q;
      last_grant_d = last_grant_q;
      ack_d        = '0;
      data_d       = data_q;
      stall_d      = stall_q;
      case (w_state_q)
         W_IDLE: begin
            if (enable && sel_found) begin
               if (fifo_full) begin
                  if (stall_q != 8'hFF) begin
                     stall_d = stall_q + 8'd1;
                  end
               end else begin
                  ack_d[sel_idx] = 1'b1;
                  data_d         = ch_data[int'(sel_idx)*FIFO_WIDTH +: FIFO_WIDTH];
                  last_grant_d   = sel_idx;
                  w_state_d      = W_WRITE;
               end
            end
         end
         W_WRITE: w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // The read sequence commits once it leaves R_IDLE; later input changes are ignored.
   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE: begin
            if (enable && !fifo_empty && tx_ready) begin
               r_state_d = R_READ;
            end
         end
         R_READ:  r_state_d = R_LOAD;
         R_LOAD:  r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_state_q    <= W_IDLE;
         r_state_q    <= R_IDLE;
         last_grant_q <= IW'(NUM_CH - 1);
         ack_q        <= '0;
         data_q       <= '0;
         stall_q      <= '0;
      end else begin
         w_state_q    <= w_state_d;
         r_state_q    <= r_state_d;
         last_grant_q <= last_grant_d;
         ack_q        <= ack_d;
         data_q       <= data_d;
         stall_q      <= stall_d;
      end
   end

   assign ch_ack       = ack_q;
   assign fifo_data_in = data_q;
   assign fifo_write_n = (w_state_q != W_WRITE);
   assign fifo_read_n  = (r_state_q != R_READ);
   assign tx_load      = (r_state_q == R_LOAD);
   assign stall_cnt    = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_arbiter
// Brief    : Directed self-checking bench for fifo_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_arbiter;

   localparam int NUM_CH = 4;
   localparam int FW     = 63;

   logic                   clk;
   logic                   reset;
   logic                   enable;
   logic [NUM_CH-1:0]      ch_req;
   logic [NUM_CH*FW-1:0]   ch_data;
   logic [NUM_CH-1:0]      ch_ack;
   logic [FW-1:0]          fifo_data_in;
   logic                   fifo_write_n;
   logic                   fifo_read_n;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   tx_ready;
   logic                   tx_load;
   logic [7:0]             stall_cnt;

   int checks;
   int failures;

   fifo_arbiter #(
      .NUM_CH     (NUM_CH),
      .FIFO_WIDTH (FW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .ch_req       (ch_req),
      .ch_data      (ch_data),
      .ch_ack       (ch_ack),
      .fifo_data_in (fifo_data_in),
      .fifo_write_n (fifo_write_n),
      .fifo_read_n  (fifo_read_n),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .tx_ready     (tx_ready),
      .tx_load      (tx_load),
      .stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [FW-1:0] mk(input int ch, input int r);
      logic [FW-1:0] v;
      v       = 63'h2A5A_0000_0000_0000;
      v[15:0] = 16'(ch * 256 + r);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      enable     = 1'b0;
      ch_req     = '0;
      fifo_full  = 1'b0;
      fifo_empty = 1'b1;
      tx_ready   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) ch_data[i*FW +: FW] = mk(i, 0);
      tick();
      tick();
      checks += 6;
      if (fifo_write_n !== 1'b1) begin failures++; $display("FAIL reset_write_n got=%b exp=1", fifo_write_n); end
      if (fifo_read_n !== 1'b1)  begin failures++; $display("FAIL reset_read_n got=%b exp=1", fifo_read_n); end
      if (ch_ack !== 4'b0000)    begin failures++; $display("FAIL reset_ack got=%b exp=0000", ch_ack); end
      if (tx_load !== 1'b0)      begin failures++; $display("FAIL reset_tx_load got=%b exp=0", tx_load); end
      if (fifo_data_in !== '0)   begin failures++; $display("FAIL reset_data got=%h exp=0", fifo_data_in); end
      if (stall_cnt !== 8'd0)    begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
      reset  = 1'b0;
      ch_req = 4'b1111;
      tick();
      tick();
      checks += 2;
      if (ch_ack !== 4'b0000)  begin failures++; $display("FAIL disabled_ack got=%b exp=0000", ch_ack); end
      if (fifo_write_n !== 1'b1) begin failures++; $display("FAIL disabled_write_n got=%b exp=1", fifo_write_n); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_ack;
      enable = 1'b1;
      ch_req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         tick();
         exp_ack = 4'b0001 << (g % 4);
         checks += 3;
         if (ch_ack !== exp_ack) begin failures++; $display("FAIL rr_ack[%0d] got=%b exp=%b", g, ch_ack, exp_ack); end
         if (fifo_write_n !== 1'b0) begin failures++; $display("FAIL rr_write_n_low[%0d] got=%b exp=0", g, fifo_write_n); end
         if (fifo_data_in !== mk(g % 4, 0)) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", g, fifo_data_in, mk(g % 4, 0)); end
         if (g == 4) ch_req = '0;
         tick();
         checks += 2;
         if (fifo_write_n !== 1'b1) begin failures++; $display("FAIL rr_write_n_gap[%0d] got=%b exp=1", g, fifo_write_n); end
         if (fifo_data_in !== mk(g % 4, 0)) begin failures++; $display("FAIL rr_data_hold[%0d] got=%h exp=%h", g, fifo_data_in, mk(g % 4, 0)); end
      end
   endtask

   task automatic test_stall();
      ch_req    = 4'b0100;
      fifo_full = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (ch_ack !== 4'b0000) begin failures++; $display("FAIL stall_no_ack[%0d] got=%b exp=0000", i, ch_ack); end
      end
      checks++;
      if (stall_cnt !== 8'd10) begin failures++; $display("FAIL stall_cnt got=%0d exp=10", stall_cnt); end
      fifo_full = 1'b0;
      tick();
      checks += 2;
      if (ch_ack !== 4'b0100) begin failures++; $display("FAIL stall_release_ack got=%b exp=0100", ch_ack); end
      if (fifo_data_in !== mk(2, 0)) begin failures++; $display("FAIL stall_release_data got=%h exp=%h", fifo_data_in, mk(2, 0)); end
      ch_req = '0;
      tick();
   endtask

   task automatic test_saturate();
      ch_req    = 4'b0001;
      fifo_full = 1'b1;
      for (int i = 0; i < 240; i++) tick();
      checks++;
      if (stall_cnt !== 8'd250) begin failures++; $display("FAIL sat_mid got=%0d exp=250", stall_cnt); end
      for (int i = 0; i < 60; i++) tick();
      checks++;
      if (stall_cnt !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d exp=255", stall_cnt); end
   endtask

   task automatic test_reset_mid_write();
      fifo_full = 1'b0;
      ch_req    = 4'b1110;
      tick();
      checks += 2;
      if (fifo_write_n !== 1'b0) begin failures++; $display("FAIL rmw_write_n got=%b exp=0", fifo_write_n); end
      if (ch_ack !== 4'b1000)    begin failures++; $display("FAIL rmw_ack got=%b exp=1000", ch_ack); end
      reset = 1'b1;
      tick();
      checks += 3;
      if (fifo_write_n !== 1'b1) begin failures++; $display("FAIL rmw_abort_write_n got=%b exp=1", fifo_write_n); end
      if (stall_cnt !== 8'd0)    begin failures++; $display("FAIL rmw_stall got=%0d exp=0", stall_cnt); end
      if (ch_ack !== 4'b0000)    begin failures++; $display("FAIL rmw_abort_ack got=%b exp=0000", ch_ack); end
      reset  = 1'b0;
      ch_req = 4'b1111;
      tick();
      checks++;
      if (ch_ack !== 4'b0001) begin failures++; $display("FAIL rmw_first_grant got=%b exp=0001", ch_ack); end
      ch_req = '0;
      tick();
   endtask

   task automatic test_read();
      fifo_empty = 1'b0;
      tx_ready   = 1'b1;
      tick();
      checks += 2;
      if (fifo_read_n !== 1'b0) begin failures++; $display("FAIL rd_n1_read_n got=%b exp=0", fifo_read_n); end
      if (tx_load !== 1'b0)     begin failures++; $display("FAIL rd_n1_load got=%b exp=0", tx_load); end
      tick();
      checks += 2;
      if (fifo_read_n !== 1'b1) begin failures++; $display("FAIL rd_n2_read_n got=%b exp=1", fifo_read_n); end
      if (tx_load !== 1'b1)     begin failures++; $display("FAIL rd_n2_load got=%b exp=1", tx_load); end
      tick();
      checks += 2;
      if (fifo_read_n !== 1'b1) begin failures++; $display("FAIL rd_n3_read_n got=%b exp=1", fifo_read_n); end
      if (tx_load !== 1'b0)     begin failures++; $display("FAIL rd_n3_load got=%b exp=0", tx_load); end
      tick();
      checks++;
      if (fifo_read_n !== 1'b0) begin failures++; $display("FAIL rd_n4_read_n got=%b exp=0", fifo_read_n); end
      // sequence already committed: dropping inputs must not cancel the load
      fifo_empty = 1'b1;
      tx_ready   = 1'b0;
      enable     = 1'b0;
      tick();
      checks++;
      if (tx_load !== 1'b1) begin failures++; $display("FAIL rd_committed_load got=%b exp=1", tx_load); end
      fifo_empty = 1'b0;
      tx_ready   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (fifo_read_n !== 1'b1) begin failures++; $display("FAIL rd_disabled[%0d] got=%b exp=1", i, fifo_read_n); end
      end
      fifo_empty = 1'b1;
      enable     = 1'b1;
      tick();
   endtask

   task automatic test_concurrent();
      logic [FW-1:0] exp_q[$];
      logic [FW-1:0] fq[$];
      logic [FW-1:0] dout;
      logic [FW-1:0] p_data;
      logic [3:0]    p_ack;
      logic          p_wn, p_rn, p_load;
      int            cnt[NUM_CH];
      int            delivered;
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      dout       = '0;
      delivered  = 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < NUM_CH; c++) exp_q.push_back(mk(c, r));
      for (int i = 0; i < NUM_CH; i++) begin
         cnt[i] = 0;
         ch_data[i*FW +: FW] = mk(i, 0);
      end
      ch_req     = 4'b1111;
      fifo_full  = 1'b0;
      fifo_empty = 1'b1;
      tx_ready   = 1'b1;
      for (int cyc = 0; cyc < 400 && delivered < 12; cyc++) begin
         p_wn   = fifo_write_n;
         p_rn   = fifo_read_n;
         p_load = tx_load;
         p_ack  = ch_ack;
         p_data = fifo_data_in;
         tick();
         if (!p_wn) begin
            checks++;
            if (!fifo_write_n) begin failures++; $display("FAIL cc_write_back_to_back cyc=%0d got=0 exp=1", cyc); end
         end
         if (p_load) begin
            checks++;
            if (exp_q.size() == 0 || dout !== exp_q[0]) begin
               failures++;
               $display("FAIL cc_delivered[%0d] got=%h exp=%h", delivered, dout, (exp_q.size() != 0) ? exp_q[0] : '0);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            delivered++;
         end
         if (!p_rn) begin
            if (fq.size() == 0) begin
               checks++; failures++;
               $display("FAIL cc_underflow cyc=%0d got=empty exp=data", cyc);
            end else begin
               dout = fq.pop_front();
            end
         end
         if (!p_wn) begin
            checks++;
            if (fq.size() >= 2) begin failures++; $display("FAIL cc_overflow cyc=%0d got=%0d exp=<2", cyc, fq.size()); end
            else fq.push_back(p_data);
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (p_ack[i]) begin
               cnt[i]++;
               if (cnt[i] >= 3) ch_req[i] = 1'b0;
               else ch_data[i*FW +: FW] = mk(i, cnt[i]);
            end
         end
         fifo_empty = (fq.size() == 0);
         fifo_full  = (fq.size() >= 2);
         tx_ready   = ((cyc % 3) != 1);
      end
      checks += 2;
      if (delivered != 12) begin failures++; $display("FAIL cc_timeout got=%0d exp=12", delivered); end
      if (fq.size() != 0)  begin failures++; $display("FAIL cc_leftover got=%0d exp=0", fq.size()); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      ch_data  = '0;
      test_reset();
      test_round_robin();
      test_stall();
      test_saturate();
      test_reset_mid_write();
      test_read();
      test_concurrent();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
`default_nettype wire
